rsa_precompute: RTL and testbench
=================================

RSA_PRECOMPUTE -- requirements
Module: rsa_precompute

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port start  input  1  single-cycle request to begin a precompute; sampled only in IDLE.
REQ-004 SHALL have port in_n  input  1024  modulus N; sampled only in the cycle start is accepted.
REQ-005 SHALL have port busy  output  1  high while a precompute is in progress.
REQ-006 SHALL have port done  output  1  one-cycle pulse; rmodn/r2modn valid from this cycle onward.
REQ-007 SHALL have port error  output  1  one-cycle pulse flagging a rejected modulus (see Configuration).
REQ-008 SHALL have port rmodn  output  1024  R mod N, R = 2^1024; feeds the exponentiator rmodn input.
REQ-009 SHALL have port r2modn  output  1024  R^2 mod N; feeds the exponentiator r2modn input.

Function
REQ-010 SHALL implement FSM states IDLE, DBL and FIN; the FSM SHALL leave IDLE only on start.
REQ-011 SHALL, on the edge that accepts start in IDLE: latch in_n into n_reg, set x to 1 and cnt to 0, set busy to 1, and go to DBL.
REQ-012 SHALL, on each DBL cycle: set x to (2*x) mod n_reg, computed as t = {x,0} (1025 bits), subtract N once if t >= N, keep the low 1024 bits; cnt increments by 1.
REQ-013 SHALL require 3 <= N < 2^1024 with N odd; outputs are undefined for other N unless rejected per REQ-024.
REQ-014 SHALL, on the DBL edge where cnt == 1023, also load the new x value into rmodn.
REQ-015 SHALL, on the DBL edge where cnt == 2047, load the new x value into r2modn and go to FIN.
REQ-016 SHALL, in FIN: assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-017 SHALL assert done exactly 2049 cycles after the start-accept edge; busy SHALL be high for exactly 2048 cycles.
REQ-018 SHALL ignore start while busy; in_n changes while busy SHALL have no effect.
REQ-019 SHALL hold rmodn and r2modn stable outside the load edges in REQ-014 and REQ-015; a new start SHALL not clear them.
REQ-020 SHALL accept start in the cycle immediately after done, i.e. while back in IDLE.

Reset
REQ-021 SHALL, on resetn low at any clock edge (including mid-DBL): go to IDLE and clear busy, done, error, rmodn, r2modn, x, cnt and n_reg to 0.
REQ-022 SHALL treat a start sampled while resetn is low as ignored.

Configuration
REQ-023 SHALL use the macro RSA_PRECOMP_CHECK_EN to select modulus checking.
REQ-024 SHALL, with RSA_PRECOMP_CHECK_EN defined: reject start with in_n[0]==0 or in_n<3; no DBL occurs; error and done pulse together on the cycle after acceptance; rmodn/r2modn unchanged.
REQ-025 SHALL, without RSA_PRECOMP_CHECK_EN: tie error to 0, perform no check, and follow REQ-013.

Structure
REQ-026 SHALL place RSA_W=1024, the FSM state typedef and the cnt width (11) in shared package rsa_pkg, which the exponentiator also imports.
REQ-027 SHALL use a single combinational sub-module mod_double (inputs x, n; output (2x) mod n) that contains the 1025-bit compare/subtract.

Verification
REQ-028 SHALL cover: N=2^1024-1, start -> done at +2049 with rmodn=1 and r2modn=1.
REQ-029 SHALL cover: N=2^1023+1 -> rmodn=2^1023-1 and r2modn=4.
REQ-030 SHALL cover: 20 random odd N with top bit set -> outputs match a big-integer model of 2^1024 mod N and 2^2048 mod N.
REQ-031 SHALL cover: second start at +100 cycles with a different N -> ignored; results match the first N.
REQ-032 SHALL cover: resetn low at +1500 -> all outputs 0 on the next cycle; a new run afterwards is correct.
REQ-033 SHALL cover, with RSA_PRECOMP_CHECK_EN: N=2^1023+2 -> error=done=1 at +1, busy stays 0, rmodn/r2modn unchanged.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA definitions: operand width, precompute FSM states and counter width.
// Also imported by the exponentiator.
package rsa_pkg;

  localparam int RSA_W = 1024;
  localparam int CNT_W = 11;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(1023);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2047);

  typedef enum logic [1:0] {
    IDLE,
    DBL,
    FIN
  } rsa_state_e;

  // A usable modulus is odd and at least 3, i.e. odd and not equal to 1.
  function automatic logic modulus_ok(input logic [RSA_W-1:0] n);
    return n[0] && (n[RSA_W-1:1] != '0);
  endfunction

endpackage

// File: rtl/rsa_precompute_mod_double.sv
// Combinational modular doubling: y = (2*x) mod n, valid for x < n.
module mod_double
  import rsa_pkg::*;
(
  input  logic [RSA_W-1:0] x,
  input  logic [RSA_W-1:0] n,
  output logic [RSA_W-1:0] y
);

  logic [RSA_W:0]   t;
  logic [RSA_W-1:0] t_minus_n;
  logic             ge;

  assign t  = {x, 1'b0};
  assign ge = (t >= {1'b0, n});

  // With x < n the difference is below n, so the borrow out of bit RSA_W can be dropped.
  assign t_minus_n = t[RSA_W-1:0] - n;
  assign y         = ge ? t_minus_n : t[RSA_W-1:0];

endmodule

// File: rtl/rsa_precompute.sv
// Montgomery constant precompute: R mod N and R^2 mod N (R = 2^1024) by 2048 modular doublings.
// Define RSA_PRECOMP_CHECK_EN to reject even moduli and moduli below 3.
module rsa_precompute
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [RSA_W-1:0] in_n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [RSA_W-1:0] rmodn,
  output logic [RSA_W-1:0] r2modn
);

  rsa_state_e       state, state_next;
  logic [RSA_W-1:0] n_reg;
  logic [RSA_W-1:0] x;
  logic [RSA_W-1:0] x_dbl;
  logic [CNT_W-1:0] cnt;
  logic             bad_n;

  mod_double u_mod_double (
    .x (x),
    .n (n_reg),
    .y (x_dbl)
  );

`ifdef RSA_PRECOMP_CHECK_EN
  logic rejected;
  logic error_q;

  assign bad_n = !modulus_ok(in_n);
  assign error = error_q;

  // A rejected request skips DBL and reports through FIN one cycle later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rejected <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (state == IDLE && start) begin
        rejected <= bad_n;
      end
      if (state == FIN) begin
        error_q <= rejected;
      end
    end
  end
`else
  assign bad_n = 1'b0;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = bad_n ? FIN : DBL;
      DBL:  if (cnt == CNT_LAST) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The 1024th doubling of 1 yields R mod N; the 2048th yields R^2 mod N.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      n_reg  <= '0;
      x      <= '0;
      cnt    <= '0;
      rmodn  <= '0;
      r2modn <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_reg <= in_n;
            x     <= RSA_W'(1);
            cnt   <= '0;
            busy  <= !bad_n;
          end
        end
        DBL: begin
          x   <= x_dbl;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_HALF) begin
            rmodn <= x_dbl;
          end
          if (cnt == CNT_LAST) begin
            r2modn <= x_dbl;
            busy   <= 1'b0;
          end
        end
        FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_precompute.sv
// Directed and model-checked bench for rsa_precompute (latency, results, start filtering, reset).
module tb_rsa_precompute;
  import rsa_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [RSA_W-1:0] in_n = '0;
  logic             busy, done, error;
  logic [RSA_W-1:0] rmodn, r2modn;

  int checks = 0;
  int errors = 0;

  rsa_precompute dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_n   (in_n),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .rmodn  (rmodn),
    .r2modn (r2modn)
  );

  always #5 clk = ~clk;

  // Called at a negedge: start is sampled by the next posedge; returns at the negedge after it.
  task automatic start_run(input logic [RSA_W-1:0] n);
    in_n  = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < RSA_W / 32; i++) in_n[i*32 +: 32] = $urandom;
  endtask

  // Counts cycles after the accept edge until done; optionally re-pulses start at restart_at.
  task automatic wait_done(input int restart_at, input logic [RSA_W-1:0] n2,
                           output int done_k, output int busy_cnt,
                           output logic [RSA_W-1:0] rm_mid, output logic [RSA_W-1:0] r2_mid);
    int k = 0;
    done_k   = -1;
    busy_cnt = 0;
    rm_mid   = '0;
    r2_mid   = '0;
    while (done_k < 0 && k <= 2300) begin
      if (busy) busy_cnt++;
      if (k == 500) begin
        rm_mid = rmodn;
        r2_mid = r2modn;
      end
      if (done) begin
        done_k = k;
      end else begin
        if (k == restart_at) begin
          start = 1'b1;
          in_n  = n2;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    in_n   = RSA_W'(7);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", error); end
    checks++; if (rmodn !== '0) begin errors++; $display("[TB] FAIL reset_rmodn got_lo %h want 0", rmodn[63:0]); end
    checks++; if (r2modn !== '0) begin errors++; $display("[TB] FAIL reset_r2modn got_lo %h want 0", r2modn[63:0]); end
    resetn = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_ignored busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [RSA_W-1:0] n_tab [5];
    logic [RSA_W-1:0] r_tab [5];
    logic [RSA_W-1:0] r2_tab [5];
    logic [RSA_W-1:0] rm, r2m;
    int dk, bc;
    // 2^1024-1: R = 1. 2^1023+1: 2^1023 = -1 so R = 2^1023-1, R^2 = 4. 7: 2^3 = 1. 2^1024-3: R = 3.
    n_tab[0] = '1;                            r_tab[0] = RSA_W'(1); r2_tab[0] = RSA_W'(1);
    n_tab[1] = {1'b1, {(RSA_W-2){1'b0}}, 1'b1}; r_tab[1] = {1'b0, {(RSA_W-1){1'b1}}}; r2_tab[1] = RSA_W'(4);
    n_tab[2] = RSA_W'(3);                     r_tab[2] = RSA_W'(1); r2_tab[2] = RSA_W'(1);
    n_tab[3] = RSA_W'(7);                     r_tab[3] = RSA_W'(2); r2_tab[3] = RSA_W'(4);
    n_tab[4] = {{(RSA_W-2){1'b1}}, 2'b01};    r_tab[4] = RSA_W'(3); r2_tab[4] = RSA_W'(9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_run(n_tab[i]);
      wait_done(-1, '0, dk, bc, rm, r2m);
      checks++; if (dk !== 2049) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d want 2049", i, dk); end
      checks++; if (bc !== 2048) begin errors++; $display("[TB] FAIL dir%0d_busy_cycles got %0d want 2048", i, bc); end
      checks++; if (rmodn !== r_tab[i]) begin errors++; $display("[TB] FAIL dir%0d_rmodn got %h..%h want %h..%h", i, rmodn[1023:960], rmodn[63:0], r_tab[i][1023:960], r_tab[i][63:0]); end
      checks++; if (r2modn !== r2_tab[i]) begin errors++; $display("[TB] FAIL dir%0d_r2modn got %h..%h want %h..%h", i, r2modn[1023:960], r2modn[63:0], r2_tab[i][1023:960], r2_tab[i][63:0]); end
      checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_error got %b want 0", i, error); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_ignore_start();
    logic [RSA_W-1:0] n1, rm, r2m;
    int dk, bc;
    n1 = {1'b1, {(RSA_W-2){1'b0}}, 1'b1};
    @(negedge clk);
    start_run(n1);
    wait_done(100, '1, dk, bc, rm, r2m);
    checks++; if (dk !== 2049) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 2049", dk); end
    checks++; if (rmodn !== {1'b0, {(RSA_W-1){1'b1}}}) begin errors++; $display("[TB] FAIL ignore_rmodn got %h..%h", rmodn[1023:960], rmodn[63:0]); end
    checks++; if (r2modn !== RSA_W'(4)) begin errors++; $display("[TB] FAIL ignore_r2modn got_lo %h want 4", r2modn[63:0]); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_second_run busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [RSA_W-1:0] rm, r2m;
    int dk, bc;
    @(negedge clk);
    start_run(RSA_W'(7));
    wait_done(-1, '0, dk, bc, rm, r2m);
    // Start is raised in the done cycle itself.
    start_run('1);
    wait_done(-1, '0, dk, bc, rm, r2m);
    checks++; if (rm !== RSA_W'(2)) begin errors++; $display("[TB] FAIL b2b_rmodn_held got_lo %h want 2", rm[63:0]); end
    checks++; if (r2m !== RSA_W'(4)) begin errors++; $display("[TB] FAIL b2b_r2modn_held got_lo %h want 4", r2m[63:0]); end
    checks++; if (dk !== 2049) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 2049", dk); end
    checks++; if (rmodn !== RSA_W'(1)) begin errors++; $display("[TB] FAIL b2b_rmodn got_lo %h want 1", rmodn[63:0]); end
    checks++; if (r2modn !== RSA_W'(1)) begin errors++; $display("[TB] FAIL b2b_r2modn got_lo %h want 1", r2modn[63:0]); end
  endtask

  task automatic test_reset_mid();
    logic [RSA_W-1:0] rm, r2m;
    int dk, bc;
    @(negedge clk);
    start_run('1);
    repeat (1500) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL midreset_error got %b want 0", error); end
    checks++; if (rmodn !== '0) begin errors++; $display("[TB] FAIL midreset_rmodn got_lo %h want 0", rmodn[63:0]); end
    checks++; if (r2modn !== '0) begin errors++; $display("[TB] FAIL midreset_r2modn got_lo %h want 0", r2modn[63:0]); end
    resetn = 1'b1;
    @(negedge clk);
    start_run({1'b1, {(RSA_W-2){1'b0}}, 1'b1});
    wait_done(-1, '0, dk, bc, rm, r2m);
    checks++; if (dk !== 2049) begin errors++; $display("[TB] FAIL after_reset_latency got %0d want 2049", dk); end
    checks++; if (rmodn !== {1'b0, {(RSA_W-1){1'b1}}}) begin errors++; $display("[TB] FAIL after_reset_rmodn got %h..%h", rmodn[1023:960], rmodn[63:0]); end
    checks++; if (r2modn !== RSA_W'(4)) begin errors++; $display("[TB] FAIL after_reset_r2modn got_lo %h want 4", r2modn[63:0]); end
  endtask

  // With the top bit set, N < R < 2N, so R mod N = R - N; R^2 mod N = (R mod N)^2 mod N.
  task automatic test_random();
    logic [RSA_W-1:0]   n, exp_r, exp_r2, rm, r2m;
    logic [2*RSA_W-1:0] sq, md;
    int dk, bc;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < RSA_W / 32; i++) n[i*32 +: 32] = $urandom;
      n[RSA_W-1] = 1'b1;
      n[0]       = 1'b1;
      exp_r  = ~n + RSA_W'(1);
      sq     = {{RSA_W{1'b0}}, exp_r} * {{RSA_W{1'b0}}, exp_r};
      md     = sq % {{RSA_W{1'b0}}, n};
      exp_r2 = md[RSA_W-1:0];
      @(negedge clk);
      start_run(n);
      wait_done(-1, '0, dk, bc, rm, r2m);
      checks++; if (rmodn !== exp_r) begin errors++; $display("[TB] FAIL rand%0d_rmodn got %h..%h want %h..%h", t, rmodn[1023:960], rmodn[63:0], exp_r[1023:960], exp_r[63:0]); end
      checks++; if (r2modn !== exp_r2) begin errors++; $display("[TB] FAIL rand%0d_r2modn got %h..%h want %h..%h", t, r2modn[1023:960], r2modn[63:0], exp_r2[1023:960], exp_r2[63:0]); end
    end
  endtask

`ifdef RSA_PRECOMP_CHECK_EN
  task automatic test_check();
    logic [RSA_W-1:0] bad_tab [2];
    logic [RSA_W-1:0] prev_r, prev_r2;
    bad_tab[0] = {1'b1, {(RSA_W-3){1'b0}}, 2'b10};
    bad_tab[1] = RSA_W'(1);
    for (int i = 0; i < 2; i++) begin
      prev_r  = rmodn;
      prev_r2 = r2modn;
      @(negedge clk);
      start_run(bad_tab[i]);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL chk%0d_busy got %b want 0", i, busy); end
      @(negedge clk);
      checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL chk%0d_error got %b want 1", i, error); end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL chk%0d_done got %b want 1", i, done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL chk%0d_busy_after got %b want 0", i, busy); end
      checks++; if (rmodn !== prev_r) begin errors++; $display("[TB] FAIL chk%0d_rmodn got_lo %h want_lo %h", i, rmodn[63:0], prev_r[63:0]); end
      checks++; if (r2modn !== prev_r2) begin errors++; $display("[TB] FAIL chk%0d_r2modn got_lo %h want_lo %h", i, r2modn[63:0], prev_r2[63:0]); end
      @(negedge clk);
      checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL chk%0d_error_pulse got %b want 0", i, error); end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef RSA_PRECOMP_CHECK_EN
    test_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
